// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI-Stream header insert/strip blocks:
// FSM state encoding plus keep-mask helpers usable at any lane count.
package axi_stream_pkg;

    // Upper bound on byte lanes the helper functions handle.
    localparam int MAX_LANES = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } strip_state_t;

    // MSB-contiguous mask of n ones within a lanes-wide keep field.
    function automatic logic [MAX_LANES-1:0] keep_from_count(input int n, input int lanes);
        logic [MAX_LANES-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if ((i < lanes) && (i >= lanes - n)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    // Number of asserted lanes in a keep field.
    function automatic int popcount_keep(input logic [MAX_LANES-1:0] keep);
        int count;
        count = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (keep[i]) begin
                count = count + 1;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/axi_stream_byte_merge.sv
// Combinational re-alignment: a left-aligned residual followed by the head of
// the next word, trimmed to total_bytes lanes with unused lanes forced to 0.
module axi_stream_byte_merge
    import axi_stream_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic [DATA_WD-1:0]      resid_data,
    input  logic [CNT_WD-1:0]       resid_bytes,
    input  logic [DATA_WD-1:0]      head_data,
    input  logic [CNT_WD-1:0]       total_bytes,
    output logic [DATA_WD-1:0]      merged_data,
    output logic [DATA_BYTE_WD-1:0] merged_keep
);

    logic [DATA_WD-1:0] combined;

    // Slide the head below the residual bytes, then zero every lane past the valid count.
    always_comb begin
        combined    = resid_data | (head_data >> {resid_bytes, 3'b000});
        merged_keep = DATA_BYTE_WD'(keep_from_count(int'(total_bytes), DATA_BYTE_WD));
        merged_data = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (merged_keep[i]) begin
                merged_data[8*i +: 8] = combined[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Removes a per-packet number of leading bytes (from a side-channel token)
// and re-packs the remaining payload into full MSB-first beats.
module axi_stream_strip_header
    import axi_stream_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  strip_cnt,
    output logic                    ready_strip,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    drop_pkt
);

    // One extra bit so a strip length of a full word (S = W) is representable.
    localparam int CNT_WD = BYTE_CNT_WD + 1;
    typedef logic [CNT_WD-1:0] cnt_t;

    strip_state_t       state;
    cnt_t               strip_bytes;
    cnt_t               flush_bytes;
    logic [DATA_WD-1:0] resid_data;

    logic               out_free;
    logic               in_hs;
    cnt_t               in_bytes;
    cnt_t               keep_bytes;
    logic               short_tail;
    logic [DATA_WD-1:0] shifted_in;

    logic [DATA_WD-1:0]      m_resid;
    cnt_t                    m_resid_bytes;
    logic [DATA_WD-1:0]      m_head;
    cnt_t                    m_total;
    logic [DATA_WD-1:0]      merged_data;
    logic [DATA_BYTE_WD-1:0] merged_keep;

    assign out_free    = !valid_out || ready_out;
    assign ready_strip = (state == ST_IDLE) && !rst;
    assign ready_in    = ((state == ST_FIRST) || (state == ST_STREAM)) && out_free && !rst;
    assign in_hs       = valid_in && ready_in;
    assign in_bytes    = cnt_t'(popcount_keep(MAX_LANES'(keep_in)));
    assign keep_bytes  = cnt_t'(DATA_BYTE_WD) - strip_bytes;
    assign short_tail  = in_bytes <= strip_bytes;
    assign shifted_in  = data_in << {strip_bytes, 3'b000};

    // Choose what the merge unit combines for the beat this state could emit.
    always_comb begin
        m_resid       = resid_data;
        m_resid_bytes = keep_bytes;
        m_head        = data_in;
        m_total       = cnt_t'(DATA_BYTE_WD);
        case (state)
            ST_FIRST: begin
                m_resid = shifted_in;
                m_head  = '0;
                m_total = in_bytes - strip_bytes;
            end
            ST_STREAM: begin
                if (last_in && short_tail) begin
                    m_total = keep_bytes + in_bytes;
                end
            end
            ST_FLUSH: begin
                m_head  = '0;
                m_total = flush_bytes;
            end
            default: begin
            end
        endcase
    end

    axi_stream_byte_merge #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .CNT_WD       (CNT_WD)
    ) u_merge (
        .resid_data  (m_resid),
        .resid_bytes (m_resid_bytes),
        .head_data   (m_head),
        .total_bytes (m_total),
        .merged_data (merged_data),
        .merged_keep (merged_keep)
    );

    // Packet FSM with the single-stage output register and drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            strip_bytes <= '0;
            flush_bytes <= '0;
            resid_data  <= '0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            keep_out    <= '0;
            last_out    <= 1'b0;
            drop_pkt    <= 1'b0;
        end else begin
            drop_pkt <= 1'b0;
            if (out_free) begin
                valid_out <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (valid_strip) begin
                        strip_bytes <= cnt_t'(strip_cnt) + cnt_t'(1);
                        state       <= ST_FIRST;
                    end
                end
                ST_FIRST: begin
                    if (in_hs) begin
                        resid_data <= shifted_in;
                        if (last_in) begin
                            if (short_tail) begin
                                drop_pkt <= 1'b1;
                            end else begin
                                valid_out <= 1'b1;
                                data_out  <= merged_data;
                                keep_out  <= merged_keep;
                                last_out  <= 1'b1;
                            end
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (in_hs) begin
                        resid_data <= shifted_in;
                        valid_out  <= 1'b1;
                        data_out   <= merged_data;
                        keep_out   <= merged_keep;
                        last_out   <= last_in && short_tail;
                        if (last_in) begin
                            if (short_tail) begin
                                state <= ST_IDLE;
                            end else begin
                                flush_bytes <= in_bytes - strip_bytes;
                                state       <= ST_FLUSH;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (out_free) begin
                        valid_out <= 1'b1;
                        data_out  <= merged_data;
                        keep_out  <= merged_keep;
                        last_out  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header: directed vector table, ready_out
// back-pressure, mid-packet reset and randomized packets against a byte-queue model.
module tb_axi_stream_strip_header;

    localparam int W = 4;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_strip;
    logic [1:0]  strip_cnt;
    logic        ready_strip;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        drop_pkt;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [1:0]       sc;
        int               nIn;
        logic [2:0][31:0] inData;
        logic [2:0][3:0]  inKeep;
        int               nOut;
        logic [2:0][31:0] outData;
        logic [2:0][3:0]  outKeep;
        int               drop;
    } vec_t;

    vec_t  vecs[5];
    beat_t txQ[$];
    beat_t expQ[$];
    byte unsigned pktBytes[$];

    int    checks    = 0;
    int    errors    = 0;
    int    dropSeen  = 0;
    int    dropExp   = 0;
    int    readyMode = 0;
    logic  prevStall = 1'b0;
    logic  prevDrop  = 1'b0;
    beat_t heldBeat;

    axi_stream_strip_header #(.DATA_WD(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .keep_in     (keep_in),
        .last_in     (last_in),
        .ready_in    (ready_in),
        .valid_strip (valid_strip),
        .strip_cnt   (strip_cnt),
        .ready_strip (ready_strip),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .keep_out    (keep_out),
        .last_out    (last_out),
        .ready_out   (ready_out),
        .drop_pkt    (drop_pkt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready: always on, toggling every cycle, or random.
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1:       ready_out = ~ready_out;
                2:       ready_out = ($urandom_range(0, 3) != 0);
                default: ready_out = 1'b1;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timeout: handshake never happened at %0t", name, $time);
    endtask

    // Output monitor: scoreboard compare, stall stability and drop pulse checks.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prevStall = 1'b0;
            prevDrop  = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("hold valid", 32'(valid_out), 32'd1);
                checkOutput("hold data", data_out, heldBeat.data);
                checkOutput("hold keep", 32'(keep_out), 32'(heldBeat.keep));
                checkOutput("hold last", 32'(last_out), 32'(heldBeat.last));
            end
            if (valid_out && ready_out) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected beat: got %h/%b last %b expected no beat", data_out, keep_out, last_out);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beat data", data_out, e.data);
                    checkOutput("beat keep", 32'(keep_out), 32'(e.keep));
                    checkOutput("beat last", 32'(last_out), 32'(e.last));
                end
            end
            if (drop_pkt) begin
                dropSeen++;
                checkOutput("drop width", 32'(prevDrop), 32'd0);
                checkOutput("strip ready after drop", 32'(ready_strip), 32'd1);
            end
            prevDrop       = drop_pkt;
            prevStall      = valid_out && !ready_out;
            heldBeat.data  = data_out;
            heldBeat.keep  = keep_out;
            heldBeat.last  = last_out;
        end
    end

    // Present a token then every beat queued in txQ, one handshake at a time.
    task automatic applyStimulus(input logic [1:0] sc);
        beat_t b;
        int    guard;
        @(posedge clk);
        #1;
        valid_strip = 1'b1;
        strip_cnt   = sc;
        guard = 0;
        @(negedge clk);
        while (!ready_strip && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_strip) begin
            timeoutFail("token");
            valid_strip = 1'b0;
            txQ.delete();
            return;
        end
        @(posedge clk);
        #1;
        valid_strip = 1'b0;
        while (txQ.size() != 0) begin
            b = txQ.pop_front();
            valid_in = 1'b1;
            data_in  = b.data;
            keep_in  = b.keep;
            last_in  = b.last;
            guard = 0;
            @(negedge clk);
            while (!ready_in && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (!ready_in) begin
                timeoutFail("beat");
                txQ.delete();
            end else begin
                @(posedge clk);
                #1;
            end
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while ((expQ.size() != 0 || valid_out) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (expQ.size() != 0 || valid_out) begin
            timeoutFail("drain");
            expQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Run one table entry: drive it, queue its expected beats, compare drops.
    task automatic runVector(input int k);
        beat_t b;
        int    dropBase;
        dropBase = dropSeen;
        for (int i = 0; i < vecs[k].nIn; i++) begin
            b.data = vecs[k].inData[i];
            b.keep = vecs[k].inKeep[i];
            b.last = (i == vecs[k].nIn - 1);
            txQ.push_back(b);
        end
        for (int i = 0; i < vecs[k].nOut; i++) begin
            b.data = vecs[k].outData[i];
            b.keep = vecs[k].outKeep[i];
            b.last = (i == vecs[k].nOut - 1);
            expQ.push_back(b);
        end
        applyStimulus(vecs[k].sc);
        @(negedge clk);
        checkOutput("ready_in after last", 32'(ready_in), 32'd0);
        waitDrain();
        checkOutput("drop count", 32'(dropSeen - dropBase), 32'(vecs[k].drop));
    endtask

    // Reference model: drop the first s bytes, re-chunk the rest into W-byte beats.
    task automatic modelPacket(input int s);
        beat_t b;
        int    rem;
        int    idx;
        rem = pktBytes.size() - s;
        if (rem <= 0) begin
            dropExp++;
            return;
        end
        idx = s;
        while (idx < pktBytes.size()) begin
            b.data = '0;
            b.keep = '0;
            for (int j = 0; j < W; j++) begin
                if (idx < pktBytes.size()) begin
                    b.data[31 - 8*j -: 8] = pktBytes[idx];
                    b.keep[3 - j]         = 1'b1;
                    idx++;
                end
            end
            b.last = (idx >= pktBytes.size());
            expQ.push_back(b);
        end
    endtask

    // Turn pktBytes into input beats, unused tail lanes filled with junk.
    task automatic buildTx();
        beat_t b;
        int    nb;
        int    idx;
        nb = (pktBytes.size() + W - 1) / W;
        for (int k = 0; k < nb; k++) begin
            b.data = $urandom;
            b.keep = '0;
            for (int j = 0; j < W; j++) begin
                idx = k * W + j;
                if (idx < pktBytes.size()) begin
                    b.data[31 - 8*j -: 8] = pktBytes[idx];
                    b.keep[3 - j]         = 1'b1;
                end
            end
            b.last = (k == nb - 1);
            txQ.push_back(b);
        end
    endtask

    initial begin
        vecs[0] = '{2'd1, 3, {32'hC1C2C3C4, 32'hB1B2B3B4, 32'hA1A2A3A4}, {4'b1100, 4'b1111, 4'b1111},
                    2, {32'h0, 32'hB3B4C1C2, 32'hA3A4B1B2}, {4'b0000, 4'b1111, 4'b1111}, 0};
        vecs[1] = '{2'd0, 3, {32'hC1C2C3C4, 32'hB1B2B3B4, 32'hA1A2A3A4}, {4'b1100, 4'b1111, 4'b1111},
                    3, {32'hC2000000, 32'hB2B3B4C1, 32'hA2A3A4B1}, {4'b1000, 4'b1111, 4'b1111}, 0};
        vecs[2] = '{2'd3, 3, {32'hC1C2C3C4, 32'hB1B2B3B4, 32'hA1A2A3A4}, {4'b1100, 4'b1111, 4'b1111},
                    2, {32'h0, 32'hC1C20000, 32'hB1B2B3B4}, {4'b0000, 4'b1100, 4'b1111}, 0};
        vecs[3] = '{2'd2, 1, {32'h0, 32'h0, 32'hD1D2D3D4}, {4'b0000, 4'b0000, 4'b1110},
                    0, {32'h0, 32'h0, 32'h0}, {4'b0000, 4'b0000, 4'b0000}, 1};
        vecs[4] = '{2'd0, 1, {32'h0, 32'h0, 32'hE1E2E3E4}, {4'b0000, 4'b0000, 4'b1111},
                    1, {32'h0, 32'h0, 32'hE2E3E400}, {4'b0000, 4'b0000, 4'b1110}, 0};

        rst         = 1'b1;
        valid_in    = 1'b0;
        data_in     = '0;
        keep_in     = '0;
        last_in     = 1'b0;
        valid_strip = 1'b0;
        strip_cnt   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset valid_out", 32'(valid_out), 32'd0);
        checkOutput("reset ready_in", 32'(ready_in), 32'd0);
        checkOutput("reset ready_strip", 32'(ready_strip), 32'd0);
        checkOutput("reset drop_pkt", 32'(drop_pkt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle ready_strip", 32'(ready_strip), 32'd1);
        checkOutput("idle ready_in", 32'(ready_in), 32'd0);

        for (int k = 0; k < 5; k++) begin
            runVector(k);
        end

        // Same packet as the S=1 case under alternating downstream ready.
        readyMode = 1;
        runVector(1);
        readyMode = 0;
        repeat (2) @(posedge clk);

        // Reset right after the second beat of a packet, then replay the S=2 case.
        txQ.push_back('{32'hA1A2A3A4, 4'b1111, 1'b0});
        txQ.push_back('{32'hB1B2B3B4, 4'b1111, 1'b0});
        applyStimulus(2'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset valid_out", 32'(valid_out), 32'd0);
        checkOutput("post-reset ready_in", 32'(ready_in), 32'd0);
        checkOutput("post-reset data_out", data_out, 32'd0);
        checkOutput("post-reset keep_out", 32'(keep_out), 32'd0);
        runVector(0);

        // Back-to-back random packets with random back-pressure.
        begin
            int dropBase;
            int s;
            int len;
            dropBase  = dropSeen;
            dropExp   = 0;
            readyMode = 2;
            for (int p = 0; p < 60; p++) begin
                s   = $urandom_range(1, W);
                len = $urandom_range(1, 13);
                pktBytes.delete();
                for (int i = 0; i < len; i++) begin
                    pktBytes.push_back(8'($urandom));
                end
                modelPacket(s);
                buildTx();
                applyStimulus(2'(s - 1));
            end
            waitDrain();
            readyMode = 0;
            repeat (3) @(negedge clk);
            checkOutput("random drop count", 32'(dropSeen - dropBase), 32'(dropExp));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
